// File: rtl/cacheline_parser_if.sv
// cacheline_parser_if: request/response bundle between the L1 I-cache read
// port (master) and the cacheline parser (slave). Big-endian bit numbering:
// bit 0 is the MSB of every field.
interface cacheline_parser_if;
  // request side
  logic          enable_i;
  logic [0:255]  cacheline_i;
  logic [0:50]   tag_i;
  logic [0:7]    index_i;
  logic [0:4]    offset_i;
  // response side
  logic [0:31]   fetchedPayload_o;
  logic          enable_o;
  logic [0:50]   tag_o;
  logic [0:7]    index_o;
  logic [0:4]    offset_o;
  logic          alignFault_o;

  modport master (
    output enable_i, cacheline_i, tag_i, index_i, offset_i,
    input  fetchedPayload_o, enable_o, tag_o, index_o, offset_o, alignFault_o
  );

  modport slave (
    input  enable_i, cacheline_i, tag_i, index_i, offset_i,
    output fetchedPayload_o, enable_o, tag_o, index_o, offset_o, alignFault_o
  );
endinterface

// File: rtl/cacheline_parser.sv
// cacheline_parser: picks the 32-bit instruction word addressed by the byte
// offset out of a 256-bit I-cache line and registers it with the address
// fields (1-cycle latency, 1 line/cycle, no backpressure).
// Optional macro CACHELINE_PARSER_ALIGN_CHECK_EN: flag requests whose byte
// offset is not word aligned (alignFault_o=1, enable_o=0).
// Bit numbering is big-endian: bit 0 is the MSB, word 0 is cacheline_i[0:31].

// One word lane: passes its word through when the select matches, else zero,
// so the lanes can simply be OR-reduced into the selected word.
module cacheline_parser_lane #(
  parameter int WORD_W = 32,
  parameter int LANE   = 0
) (
  input  logic [0:WORD_W-1] word_i,
  input  logic [2:0]        sel_i,
  output logic [0:WORD_W-1] word_o
);
  assign word_o = (sel_i == 3'(LANE)) ? word_i : '0;
endmodule

module cacheline_parser (
  input  logic                  clock_i,
  input  logic                  reset_i,
  cacheline_parser_if.slave     bus
);
  localparam int NUM_WORDS = 8;
  localparam int WORD_W    = 32;

  // Upper three offset bits (big-endian [0:2]) are the word index; the low
  // two bits are the byte within the word and never steer the select.
  logic [2:0] sel;
  assign sel = bus.offset_i[0:2];

  logic [NUM_WORDS-1:0][0:WORD_W-1] lane_word;
  logic [0:WORD_W-1]                word_sel;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_lane
    cacheline_parser_lane #(
      .WORD_W (WORD_W),
      .LANE   (k)
    ) u_lane (
      .word_i (bus.cacheline_i[k*WORD_W +: WORD_W]),
      .sel_i  (sel),
      .word_o (lane_word[k])
    );
  end

  // OR-reduce the one-hot lanes into the selected word
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NUM_WORDS; k++) word_sel |= lane_word[k];
  end

  logic [0:WORD_W-1] payload_d, payload_q;
  logic              enable_d,  enable_q;
  logic [0:50]       tag_d,     tag_q;
  logic [0:7]        index_d,   index_q;
  logic [0:4]        offset_d,  offset_q;
`ifdef CACHELINE_PARSER_ALIGN_CHECK_EN
  logic              fault_d,   fault_q;
  logic              misaligned;
  assign misaligned = |bus.offset_i[3:4];
`endif

  // Next-state: capture on enable, otherwise hold data and drop valid
  always_comb begin
    payload_d = payload_q;
    tag_d     = tag_q;
    index_d   = index_q;
    offset_d  = offset_q;
    enable_d  = 1'b0;
`ifdef CACHELINE_PARSER_ALIGN_CHECK_EN
    fault_d   = fault_q;
`endif
    if (bus.enable_i) begin
      payload_d = word_sel;
      tag_d     = bus.tag_i;
      index_d   = bus.index_i;
      offset_d  = bus.offset_i;
`ifdef CACHELINE_PARSER_ALIGN_CHECK_EN
      // misaligned fetch still records the word and address for debug,
      // but is not presented as a valid instruction
      enable_d  = ~misaligned;
      fault_d   = misaligned;
`else
      enable_d  = 1'b1;
`endif
    end
  end

  // Output register; async reset clears everything, including in-flight data
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      payload_q <= '0;
      enable_q  <= 1'b0;
      tag_q     <= '0;
      index_q   <= '0;
      offset_q  <= '0;
`ifdef CACHELINE_PARSER_ALIGN_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      payload_q <= payload_d;
      enable_q  <= enable_d;
      tag_q     <= tag_d;
      index_q   <= index_d;
      offset_q  <= offset_d;
`ifdef CACHELINE_PARSER_ALIGN_CHECK_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign bus.fetchedPayload_o = payload_q;
  assign bus.enable_o         = enable_q;
  assign bus.tag_o            = tag_q;
  assign bus.index_o          = index_q;
  assign bus.offset_o         = offset_q;
`ifdef CACHELINE_PARSER_ALIGN_CHECK_EN
  assign bus.alignFault_o     = fault_q;
`else
  assign bus.alignFault_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_parser.sv
// tb_cacheline_parser: directed literal checks plus randomized traffic
// compared every cycle against a value-level model of the parser.
module tb_cacheline_parser;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic cmp_on;

  cacheline_parser_if bus ();

  cacheline_parser dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CACHELINE_PARSER_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // ---------------- reference model (numeric, MSB-first words) -------------
  logic [31:0] m_payload;
  logic        m_en;
  logic        m_fault;
  logic [50:0] m_tag;
  logic [7:0]  m_idx;
  logic [4:0]  m_off;

  function automatic logic [31:0] word_of(logic [255:0] line, int unsigned byte_off);
    int unsigned w;
    logic [255:0] sh;
    w  = byte_off / 4;               // 4 bytes per word
    sh = line >> (32 * (7 - w));     // word 0 is the most significant word
    return sh[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_payload <= '0; m_en <= 1'b0; m_fault <= 1'b0;
      m_tag <= '0; m_idx <= '0; m_off <= '0;
    end else begin
      m_en <= 1'b0;
      if (bus.enable_i) begin
        logic [255:0] ln;
        logic [4:0]   of;
        bit           mis;
        ln  = bus.cacheline_i;
        of  = bus.offset_i;
        mis = ALIGN_EN && (of % 4 != 0);
        m_payload <= word_of(ln, of);
        m_tag     <= bus.tag_i;
        m_idx     <= bus.index_i;
        m_off     <= of;
        m_en      <= !mis;
        m_fault   <= mis;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one compare process: every negedge while enabled, DUT vs model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_payload", 64'(bus.fetchedPayload_o), 64'(m_payload));
      chk("m_enable",  64'(bus.enable_o),         64'(m_en));
      chk("m_tag",     64'(bus.tag_o),            64'(m_tag));
      chk("m_index",   64'(bus.index_o),          64'(m_idx));
      chk("m_offset",  64'(bus.offset_o),         64'(m_off));
      chk("m_fault",   64'(bus.alignFault_o),     64'(m_fault));
    end
  end

  task automatic drive(input logic en, input logic [255:0] line,
                       input logic [50:0] tag, input logic [7:0] idx, input logic [4:0] off);
    bus.enable_i    = en;
    bus.cacheline_i = line;
    bus.tag_i       = tag;
    bus.index_i     = idx;
    bus.offset_i    = off;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_payload"}, 64'(bus.fetchedPayload_o), 64'd0);
    chk({name, "_enable"},  64'(bus.enable_o),         64'd0);
    chk({name, "_tag"},     64'(bus.tag_o),            64'd0);
    chk({name, "_index"},   64'(bus.index_o),          64'd0);
    chk({name, "_offset"},  64'(bus.offset_o),         64'd0);
    chk({name, "_fault"},   64'(bus.alignFault_o),     64'd0);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  localparam logic [255:0] L1 =
    256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;
  localparam logic [255:0] L2 =
    256'h88888888_99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF;
  localparam logic [255:0] L3 =
    256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;

  initial begin
    logic [31:0] sweep_exp;
    checks = 0; errors = 0; cmp_on = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, rand_line(), 51'h5A5A, 8'h77, 5'd12);

    // asynchronous reset with no clock edge in between
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk); @(negedge clk);
    drive(1'b0, L1, 51'd0, 8'd0, 5'd0);
    rst_n = 1'b1;
    @(posedge clk); #1 chk_zero("rst_idle");
    cmp_on = 1'b1;

    // directed: first line, offset 4
    @(negedge clk); drive(1'b1, L1, 51'd10, 8'd15, 5'd4);
    @(posedge clk); #1;
    chk("d1_payload", 64'(bus.fetchedPayload_o), 64'hEEEEEEEE);
    chk("d1_enable",  64'(bus.enable_o), 64'd1);
    chk("d1_tag",     64'(bus.tag_o),    64'd10);
    chk("d1_index",   64'(bus.index_o),  64'd15);
    chk("d1_offset",  64'(bus.offset_o), 64'd4);

    // back-to-back: second line, offset 16
    @(negedge clk); drive(1'b1, L2, 51'd12, 8'd3, 5'd16);
    @(posedge clk); #1;
    chk("d2_payload", 64'(bus.fetchedPayload_o), 64'hCCCCCCCC);
    chk("d2_enable",  64'(bus.enable_o), 64'd1);
    chk("d2_tag",     64'(bus.tag_o),    64'd12);
    chk("d2_index",   64'(bus.index_o),  64'd3);
    chk("d2_offset",  64'(bus.offset_o), 64'd16);

    // idle: outputs hold, valid drops
    @(negedge clk); drive(1'b0, L3, 51'd1, 8'd2, 5'd4);
    @(posedge clk); #1;
    chk("d3_enable",  64'(bus.enable_o), 64'd0);
    chk("d3_payload", 64'(bus.fetchedPayload_o), 64'hCCCCCCCC);
    chk("d3_tag",     64'(bus.tag_o),    64'd12);
    chk("d3_index",   64'(bus.index_o),  64'd3);
    chk("d3_offset",  64'(bus.offset_o), 64'd16);

    // aligned offset sweep on the first line
    sweep_exp = 32'hFFFFFFFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); drive(1'b1, L1, 51'(k), 8'(k), 5'(4 * k));
      @(posedge clk); #1;
      chk($sformatf("sweep%0d_payload", k), 64'(bus.fetchedPayload_o), 64'(sweep_exp));
      chk($sformatf("sweep%0d_enable", k),  64'(bus.enable_o), 64'd1);
      sweep_exp = sweep_exp - 32'h11111111;
    end

    // misaligned offset 6: word 1 selected, low bits only matter for the flag
    @(negedge clk); drive(1'b1, L1, 51'd7, 8'd9, 5'd6);
    @(posedge clk); #1;
    chk("mis_payload", 64'(bus.fetchedPayload_o), 64'hEEEEEEEE);
    chk("mis_offset",  64'(bus.offset_o), 64'd6);
    chk("mis_enable",  64'(bus.enable_o),     ALIGN_EN ? 64'd0 : 64'd1);
    chk("mis_fault",   64'(bus.alignFault_o), ALIGN_EN ? 64'd1 : 64'd0);

    // randomized traffic with occasional mid-stream resets
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 3) != 0), rand_line(), {19'($urandom()), 32'($urandom())},
            8'($urandom()), 5'($urandom()));
      if ($urandom_range(0, 40) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk); drive(1'b0, L1, 51'd0, 8'd0, 5'd0);
    @(negedge clk);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
